// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the sequential ALU.
package alu_pkg;

  localparam logic [2:0] OP_FWD = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_ROR = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/alu_comb.sv
// Combinational single-cycle ALU operations and their arithmetic flags.
// MUL yields 0 and ROR passes DATA1 through; both are finished by the
// iterative datapath in seq_alu (ROR by 0 uses this pass-through directly).
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             overflow
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  // Select the result and flags for the current opcode
  always_comb begin
    y        = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    case (op)
      OP_FWD: y = b;
      OP_ADD: begin
        y        = sum[WIDTH-1:0];
        carry    = sum[WIDTH];
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_SUB: begin
        y        = diff[WIDTH-1:0];
        carry    = diff[WIDTH];  // borrow out: a < b unsigned
        overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_XOR: y = a ^ b;
      OP_ROR: y = a;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: single-cycle ops via alu_comb, iterative shift-add MUL
// and bit-serial rotate-right, with a registered result held until consumed.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  input  logic [2:0]       SELECT,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] RESULT,
  output logic             ZERO,
  output logic             CARRY,
  output logic             OVERFLOW
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           state;
  logic             is_mul;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] rot;

  logic [WIDTH-1:0] comb_y;
  logic             comb_c;
  logic             comb_v;
  logic [CNT_W-1:0] amount;
  logic             accept;
  logic             iterative;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] rot_next;
  logic [WIDTH-1:0] iter_y;

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .a        (DATA1),
    .b        (DATA2),
    .op       (SELECT),
    .y        (comb_y),
    .carry    (comb_c),
    .overflow (comb_v)
  );

  assign amount    = DATA2[CNT_W-1:0];
  assign accept    = (state == ST_IDLE) && IN_VALID;
  assign iterative = (SELECT == OP_MUL) || ((SELECT == OP_ROR) && (amount != '0));
  assign acc_next  = acc + (mplier[0] ? mcand : '0);
  assign rot_next  = {rot[0], rot[WIDTH-1:1]};
  assign iter_y    = is_mul ? acc_next : rot_next;

  // Ready is forced low while reset is held, even though the state reads IDLE
  assign IN_READY  = (state == ST_IDLE) && !RESET;
  assign OUT_VALID = (state == ST_DONE);

  // Control FSM plus output registers; cnt holds remaining iterations minus one
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= ST_IDLE;
      is_mul   <= 1'b0;
      cnt      <= '0;
      RESULT   <= '0;
      ZERO     <= 1'b0;
      CARRY    <= 1'b0;
      OVERFLOW <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (IN_VALID) begin
            if (iterative) begin
              is_mul <= (SELECT == OP_MUL);
              cnt    <= (SELECT == OP_MUL) ? CNT_W'(WIDTH - 1) : amount - 1'b1;
              state  <= ST_BUSY;
            end else begin
              RESULT   <= comb_y;
              ZERO     <= (comb_y == '0);
              CARRY    <= comb_c;
              OVERFLOW <= comb_v;
              state    <= ST_DONE;
            end
          end
        end
        ST_BUSY: begin
          if (cnt == '0) begin
            RESULT   <= iter_y;
            ZERO     <= (iter_y == '0);
            CARRY    <= 1'b0;
            OVERFLOW <= 1'b0;
            state    <= ST_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DONE: begin
          if (OUT_READY) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Iteration datapath: operand capture at accept, one step per BUSY cycle
  always_ff @(posedge CLK) begin
    if (accept) begin
      mcand  <= DATA1;
      mplier <= DATA2;
      acc    <= '0;
      rot    <= DATA1;
    end else if (state == ST_BUSY) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      rot    <= rot_next;
    end
  end

endmodule
